// File: rtl/best_d_seq.sv
// -----------------------------------------------------------------------------
// best_d_seq
//
// Chooses the split parameter d = 2^u for the constant-weight encoder.
// A request (n, t) is accepted with a valid/ready handshake. t is mapped to a
// small integer theta, p = n * theta is formed by a serial shift-add multiply
// (one theta bit per cycle), q = p >> FRAC is taken, and u is the smallest
// value in [U_MIN, U_MAX] with q <= 2^u. If q exceeds 2^U_MAX then u is clamped
// to U_MAX and sat is raised. The result is held until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   block can accept a request (high exactly when idle)
//   n          code length parameter, unsigned, N_W bits
//   t          error-weight parameter, unsigned, T_W bits
//   out_valid  result valid; held until out_ready
//   out_ready  consumer accepts the result
//   d          2^u, D_W bits
//   u          log2 of d, U_W bits
//   sat        q exceeded 2^U_MAX and u was clamped
// -----------------------------------------------------------------------------
module best_d_seq #(
    parameter int N_W     = 11,
    parameter int T_W     = 6,
    parameter int THETA_W = 5,
    parameter int FRAC    = 5,
    parameter int U_MIN   = 2,
    parameter int U_MAX   = 9,
    parameter int U_W     = 4,
    localparam int D_W    = U_MAX + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] n,
    input  logic [T_W-1:0] t,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] d,
    output logic [U_W-1:0] u,
    output logic           sat
);

    // Product accumulator is wide enough for n * (2^THETA_W - 1): no overflow.
    localparam int ACC_W = N_W + THETA_W;
    // Width of q after dropping the fractional bits.
    localparam int Q_W   = ACC_W - FRAC;
    // Compare width: must hold both every q and 2^U_MAX without truncation.
    localparam int CMP_W = (Q_W > U_MAX + 2) ? Q_W : U_MAX + 2;
    localparam int CNT_W = (THETA_W > 1) ? $clog2(THETA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THETA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ENC,
        S_DONE
    } state_t;

    state_t               state_q,     state_d;
    logic [ACC_W-1:0]     acc_q,       acc_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [N_W-1:0]       n_q,         n_d;
    logic [THETA_W-1:0]   theta_q,     theta_d;
    logic [D_W-1:0]       d_q,         d_d;
    logic [U_W-1:0]       u_q,         u_d;
    logic                 sat_q,       sat_d;
    logic                 out_valid_q, out_valid_d;

    // -------------------------------------------------------------------------
    // theta lookup. Small t means few errors, so the split can be coarser
    // (larger theta); t of 22 and above collapses the product to zero.
    // -------------------------------------------------------------------------
    function automatic logic [THETA_W-1:0] theta_of(input logic [T_W-1:0] tv);
        logic [31:0] tw;
        logic [31:0] th;
        tw = 32'(tv);
        if (tw >= 32'd22)      th = 32'd0;
        else if (tw >= 32'd11) th = 32'd1;
        else if (tw >= 32'd8)  th = 32'd2;
        else if (tw >= 32'd6)  th = 32'd3;
        else if (tw == 32'd5)  th = 32'd4;
        else if (tw == 32'd4)  th = 32'd5;
        else if (tw == 32'd3)  th = 32'd6;
        else if (tw == 32'd2)  th = 32'd9;
        else                   th = 32'd16;
        return THETA_W'(th);
    endfunction

    // -------------------------------------------------------------------------
    // Ceiling-log2 with clamping. One comparator per candidate u checks
    // q <= 2^u at full width; the smallest passing candidate wins. Exact
    // powers of two therefore map to their own exponent, not the next one.
    // -------------------------------------------------------------------------
    logic [CMP_W-1:0]     q_ext;
    logic [U_MAX:U_MIN]   fits;
    logic [U_W-1:0]       u_sel;
    logic                 sat_sel;

    assign q_ext = CMP_W'(acc_q[ACC_W-1:FRAC]);

    generate
        for (genvar gi = U_MIN; gi <= U_MAX; gi++) begin : g_fit
            assign fits[gi] = (q_ext <= (CMP_W'(1) << gi));
        end
    endgenerate

    always_comb begin
        // Nothing fits means q > 2^U_MAX: clamp and flag.
        u_sel   = U_W'(U_MAX);
        sat_sel = 1'b1;
        for (int i = U_MAX; i >= U_MIN; i--) begin
            if (fits[i]) begin
                u_sel   = U_W'(i);
                sat_sel = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        theta_d     = theta_q;
        d_d         = d_q;
        u_d         = u_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    n_d     = n;
                    theta_d = theta_of(t);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end

            S_MUL: begin
                // One theta bit per cycle, LSB first; the partial product for
                // bit cnt is n shifted into that bit's weight.
                if (theta_q[cnt_q]) begin
                    acc_d = acc_q + (ACC_W'(n_q) << cnt_q);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ENC;
                end
            end

            S_ENC: begin
                u_d         = u_sel;
                d_d         = D_W'(1) << u_sel;
                sat_d       = sat_sel;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end

            S_DONE: begin
                // d/u/sat are not cleared here; they stay until the next ENC.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            theta_q     <= '0;
            d_q         <= '0;
            u_q         <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            theta_q     <= theta_d;
            d_q         <= d_d;
            u_q         <= u_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ready is purely a function of state so it is also high during reset.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign u         = u_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_best_d_seq.sv
module tb_best_d_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] n;
    logic [5:0]  t;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  d;
    logic [3:0]  u;
    logic        sat;

    int n_cmp = 0;
    int n_err = 0;

    best_d_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .t         (t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .u         (u),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result packing shared by the DUT view and the model: sat@14, u@13:10, d@9:0.
    function automatic logic [31:0] pk(input int s, input int uu, input int dd);
        return 32'((s << 14) | (uu << 10) | dd);
    endfunction

    function automatic logic [31:0] dut_res();
        return {17'd0, sat, u, d};
    endfunction

    // Reference: theta table, true product, integer ceil-log2 with clamping.
    function automatic logic [31:0] model(input int nv, input int tv);
        int th, p, q, uu, s;
        if (tv >= 22)      th = 0;
        else if (tv >= 11) th = 1;
        else if (tv >= 8)  th = 2;
        else if (tv >= 6)  th = 3;
        else if (tv == 5)  th = 4;
        else if (tv == 4)  th = 5;
        else if (tv == 3)  th = 6;
        else if (tv == 2)  th = 9;
        else               th = 16;
        p = nv * th;
        q = p / 32;
        s = 0;
        if (q <= 4)        uu = 2;
        else if (q > 512)  begin uu = 9; s = 1; end
        else               uu = $clog2(q);
        return pk(s, uu, 1 << uu);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE (called #1 after a rising edge), wait for
    // the result, check latency and value. Leaves the block in DONE.
    task automatic run_req(input string tag, input int nv, input int tv,
                           input int eu, input int ed, input int es);
        int lat;
        check({tag, "/ready"}, 32'(in_ready), 32'd1);
        n         = 11'(nv);
        t         = 6'(tv);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'd6);
        check({tag, "/result"}, dut_res(), pk(es, eu, ed));
        $display("req %s n=%0d t=%0d -> d=%0d u=%0d sat=%0d lat=%0d", tag, nv, tv, d, u, sat, lat);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/ovalid_clr"}, 32'(out_valid), 32'd0);
        check({tag, "/ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] expq[$];
        int acc_cnt, got, cyc;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n         = '0;
        t         = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst/in_ready", 32'(in_ready), 32'd1);
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/result", dut_res(), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the boundary list
        run_req("theta0", 1024, 50, 2, 4, 0);      consume("theta0");
        run_req("q64", 1024, 10, 6, 64, 0);        consume("q64");
        run_req("q65", 1040, 10, 7, 128, 0);       consume("q65");
        run_req("q288", 1024, 2, 9, 512, 0);       consume("q288");
        run_req("sat", 2047, 1, 9, 512, 1);        consume("sat");

        // Backpressure: result held, requests ignored
        run_req("bp", 1024, 2, 9, 512, 0);
        held = dut_res();
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            n        = 11'($urandom);
            t        = 6'(0);
            @(posedge clk); #1;
            check("bp/out_valid", 32'(out_valid), 32'd1);
            check("bp/in_ready", 32'(in_ready), 32'd0);
            check("bp/held", dut_res(), held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp/release_ready", 32'(in_ready), 32'd1);
        check("bp/release_ovalid", 32'(out_valid), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("bp/no_second", 32'(out_valid), 32'd0);
        check("bp/still_idle", 32'(in_ready), 32'd1);

        // Reset in the third multiply cycle
        n = 11'd500; t = 6'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst/out_valid", 32'(out_valid), 32'd0);
        check("midrst/result", dut_res(), 32'd0);
        check("midrst/in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst/discarded", 32'(out_valid), 32'd0);
        check("midrst/ready_after", 32'(in_ready), 32'd1);
        run_req("after_rst", 100, 5, 4, 16, 0);    consume("after_rst");

        // Random sweep: scoreboard of expected results in acceptance order
        acc_cnt = 0; got = 0; cyc = 0;
        while ((acc_cnt < 1000 || expq.size() > 0) && cyc < 60000) begin
            if (acc_cnt < 1000) begin
                in_valid = 1'($urandom_range(0, 1));
                n        = 11'($urandom);
                t        = 6'($urandom_range(0, 31));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                expq.push_back(model(int'(n), int'(t)));
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                check("rand/pending", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    check("rand/result", dut_res(), expq.pop_front());
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand/timeout", 32'(cyc < 60000), 32'd1);
        check("rand/count", 32'(got), 32'(acc_cnt));
        $display("random sweep: accepted=%0d returned=%0d cycles=%0d", acc_cnt, got, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
